// File: rtl/reg_file_pkg.sv
// Shared sizing and types for the 4-entry, 4-bit register file.
package reg_file_pkg;
  localparam int REG_WIDTH = 4;
  localparam int N_REGS    = 4;
  localparam int ADDR_W    = 2;

  typedef logic [REG_WIDTH-1:0] reg_word_t;
endpackage

// File: rtl/reg_bank_decode_4_if.sv
// Write-side bus of the register bank: address/strobe/data in, decode and register contents out.
interface reg_bank_decode_4_if
  import reg_file_pkg::*;
#(
  parameter int WIDTH = REG_WIDTH
);
  logic [ADDR_W-1:0] i_reg_write;
  logic              i_write_enable;
  logic [WIDTH-1:0]  i_port_write;
  logic [N_REGS-1:0] o_one_hot;
  logic [N_REGS-1:0] o_write_en;
  logic [WIDTH-1:0]  o_q0;
  logic [WIDTH-1:0]  o_q1;
  logic [WIDTH-1:0]  o_q2;
  logic [WIDTH-1:0]  o_q3;

  modport master (
    output i_reg_write, i_write_enable, i_port_write,
    input  o_one_hot, o_write_en, o_q0, o_q1, o_q2, o_q3
  );

  modport slave (
    input  i_reg_write, i_write_enable, i_port_write,
    output o_one_hot, o_write_en, o_q0, o_q1, o_q2, o_q3
  );
endinterface

// File: rtl/register_en_4.sv
// Enable-gated storage register with synchronous active-low clear.
module register_en_4
  import reg_file_pkg::*;
#(
  parameter int WIDTH = REG_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);
  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] q_q;

  always_comb begin
    q_d = q_q;
    if (i_en) q_d = i_d;
  end

  // Clear wins over a load presented on the same edge.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) q_q <= '0;
    else          q_q <= q_d;
  end

  assign o_q = q_q;
endmodule

// File: rtl/reg_bank_decode_4.sv
// Write side of the 4x4 register file: one-hot address decode gating four enable registers.
module reg_bank_decode_4 #(
  parameter int WIDTH  = reg_file_pkg::REG_WIDTH,
  parameter int N_REGS = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  reg_bank_decode_4_if.slave bus
);
  import reg_file_pkg::*;

  logic [N_REGS-1:0] one_hot;
  logic [N_REGS-1:0] write_en;
  logic [WIDTH-1:0]  q [N_REGS];

  // Fully covered case so an X address only yields a don't-care, never a latch.
  always_comb begin
    one_hot = '0;
    case (bus.i_reg_write)
      2'd0:    one_hot = 4'b0001;
      2'd1:    one_hot = 4'b0010;
      2'd2:    one_hot = 4'b0100;
      2'd3:    one_hot = 4'b1000;
      default: one_hot = 'x;
    endcase
  end

  always_comb begin
    write_en = '0;
    if (bus.i_write_enable) write_en = one_hot;
  end

  for (genvar k = 0; k < N_REGS; k++) begin : g_reg
    register_en_4 #(
      .WIDTH(WIDTH)
    ) u_reg (
      .i_clk  (i_clk),
      .i_rst_n(i_rst_n),
      .i_en   (write_en[k]),
      .i_d    (bus.i_port_write),
      .o_q    (q[k])
    );
  end

  assign bus.o_one_hot  = one_hot;
  assign bus.o_write_en = write_en;
  assign bus.o_q0       = q[0];
  assign bus.o_q1       = q[1];
  assign bus.o_q2       = q[2];
  assign bus.o_q3       = q[3];
endmodule

// File: tb/tb_reg_bank_decode_4.sv
// Scoreboard bench for reg_bank_decode_4: driver queues expectations, negedge monitor compares.
module tb_reg_bank_decode_4;
  import reg_file_pkg::*;

  typedef struct {
    string          tag;
    logic [3:0]     oh;
    logic [3:0]     we;
    reg_word_t      q0, q1, q2, q3;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  exp_t sb [$];
  reg_word_t model [4];

  reg_bank_decode_4_if bus ();

  reg_bank_decode_4 dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input string f, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s got %h expected %h", tag, f, act, exp);
    end
  endtask

  // Monitor: outputs are stable mid-cycle, so sample on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk(e.tag, "one_hot",  bus.o_one_hot,  e.oh);
        chk(e.tag, "write_en", bus.o_write_en, e.we);
        chk(e.tag, "q0", bus.o_q0, e.q0);
        chk(e.tag, "q1", bus.o_q1, e.q1);
        chk(e.tag, "q2", bus.o_q2, e.q2);
        chk(e.tag, "q3", bus.o_q3, e.q3);
      end
    end
  end

  // Called just after a rising edge: drive, queue expectation, take the next edge, update model.
  task automatic cycle(input logic r, input logic w, input logic [1:0] a, input logic [3:0] d,
                       input string tag);
    exp_t e;
    logic [3:0] oh;
    rst_n              = r;
    bus.i_write_enable = w;
    bus.i_reg_write    = a;
    bus.i_port_write   = d;
    case (a)
      2'd0: oh = 4'b0001;
      2'd1: oh = 4'b0010;
      2'd2: oh = 4'b0100;
      default: oh = 4'b1000;
    endcase
    e.tag = tag;
    e.oh  = oh;
    e.we  = w ? oh : 4'b0000;
    e.q0  = model[0];
    e.q1  = model[1];
    e.q2  = model[2];
    e.q3  = model[3];
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (!r) begin
      for (int i = 0; i < 4; i++) model[i] = '0;
    end else if (w) begin
      model[a] = d;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n              = 1'b0;
    bus.i_write_enable = 1'b0;
    bus.i_reg_write    = 2'd0;
    bus.i_port_write   = 4'h0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) model[i] = '0;

    cycle(1, 0, 2'd0, 4'h0, "reset_state");
    // Decoder sweep with strobe low
    cycle(1, 0, 2'd0, 4'h0, "dec0");
    cycle(1, 0, 2'd1, 4'h0, "dec1");
    cycle(1, 0, 2'd2, 4'h0, "dec2");
    cycle(1, 0, 2'd3, 4'h0, "dec3");
    // Write isolation
    cycle(1, 1, 2'd0, 4'hA, "wr0");
    cycle(1, 1, 2'd1, 4'h5, "wr1");
    cycle(1, 1, 2'd2, 4'hC, "wr2");
    cycle(1, 1, 2'd3, 4'h3, "wr3");
    // Hold with data F on every address
    cycle(1, 0, 2'd0, 4'hF, "hold0");
    cycle(1, 0, 2'd1, 4'hF, "hold1");
    cycle(1, 0, 2'd2, 4'hF, "hold2");
    cycle(1, 0, 2'd3, 4'hF, "hold3");
    // Plain reset after all registers written
    cycle(0, 0, 2'd1, 4'h0, "rst_edge");
    cycle(1, 0, 2'd0, 4'h0, "after_rst");
    // Reset priority over a write to address 2
    cycle(1, 1, 2'd2, 4'h7, "pre_prio");
    cycle(1, 1, 2'd1, 4'h6, "pre_prio1");
    cycle(0, 1, 2'd2, 4'h9, "rst_prio");
    cycle(1, 0, 2'd2, 4'h0, "after_prio");
    // Refill, then overwrite address 3 back to back
    cycle(1, 1, 2'd0, 4'h2, "fill0");
    cycle(1, 1, 2'd2, 4'hB, "fill2");
    cycle(1, 1, 2'd3, 4'h1, "ovw1");
    cycle(1, 1, 2'd3, 4'hE, "ovwE");
    cycle(1, 0, 2'd3, 4'h0, "ovw_chk1");
    cycle(1, 0, 2'd0, 4'h0, "ovw_chk2");

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
